// File: rtl/rename_unit.sv
// Register renamer: maps source ARNs through the RAT and allocates destination PRNs from a circular free list.
// It also hands each destination's overwritten mapping to the ROB and takes freed PRNs back.
module rename_unit #(
  parameter int PRN_BITS     = 6,
  parameter int ARCH_REGS    = 32,
  parameter int MAX_OPERANDS = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                inst_valid,
  output logic                inst_ready,
  input  logic [63:0]         pc,
  input  logic                src_valid            [MAX_OPERANDS],
  input  logic [5:0]          src_arn              [MAX_OPERANDS],
  input  logic                dst_valid            [MAX_OPERANDS],
  input  logic [5:0]          dst_arn              [MAX_OPERANDS],
  output logic                out_valid,
  input  logic                out_ready,
  output logic [63:0]         out_pc,
  output logic [PRN_BITS-1:0] out_src_prn          [MAX_OPERANDS],
  output logic                out_dst_valid        [MAX_OPERANDS],
  output logic [PRN_BITS-1:0] out_dst_prn          [MAX_OPERANDS],
  output logic                mapping_inputs_valid [MAX_OPERANDS],
  output logic [PRN_BITS-1:0] mapping_inputs_prn   [MAX_OPERANDS],
  output logic [5:0]          mapping_inputs_arn   [MAX_OPERANDS],
  input  logic                freed_prns_valid     [MAX_OPERANDS],
  input  logic [PRN_BITS-1:0] freed_prns           [MAX_OPERANDS]
);
  localparam int DEPTH = 1 << PRN_BITS;

  typedef logic [PRN_BITS-1:0] prn_t;
  typedef logic [PRN_BITS:0]   cnt_t;

  prn_t rat [ARCH_REGS];
  prn_t fl  [DEPTH];
  prn_t head, tail;
  cnt_t free_count, need, pop_cnt, push_cnt;
  logic accept;
  prn_t src_prn_n [MAX_OPERANDS];
  prn_t dst_prn_n [MAX_OPERANDS];
  prn_t map_prn_n [MAX_OPERANDS];
  prn_t push_idx  [MAX_OPERANDS];

  always_comb begin
    need     = '0;
    push_cnt = '0;
    for (int unsigned j = 0; j < MAX_OPERANDS; j++) begin
      src_prn_n[j] = '0;
      dst_prn_n[j] = '0;
      map_prn_n[j] = '0;
      push_idx[j]  = '0;
    end
    for (int unsigned i = 0; i < MAX_OPERANDS; i++) begin
      if (src_valid[i]) begin
        for (int unsigned r = 0; r < ARCH_REGS; r++)
          if (src_arn[i] == 6'(r)) src_prn_n[i] = rat[r];
      end
    end
    // A repeated ARN's old mapping is the PRN given to the nearest lower slot, not the RAT entry.
    for (int unsigned j = 0; j < MAX_OPERANDS; j++) begin
      if (dst_valid[j]) begin
        dst_prn_n[j] = fl[head + need[PRN_BITS-1:0]];
        need         = need + cnt_t'(1);
        for (int unsigned r = 0; r < ARCH_REGS; r++)
          if (dst_arn[j] == 6'(r)) map_prn_n[j] = rat[r];
        for (int unsigned k = 0; k < j; k++)
          if (dst_valid[k] && dst_arn[k] == dst_arn[j]) map_prn_n[j] = dst_prn_n[k];
      end
    end
    for (int unsigned i = 0; i < MAX_OPERANDS; i++) begin
      push_idx[i] = tail + push_cnt[PRN_BITS-1:0];
      if (freed_prns_valid[i]) push_cnt = push_cnt + cnt_t'(1);
    end
    inst_ready = (!out_valid || out_ready) && (free_count >= need);
    accept     = inst_valid && inst_ready;
    pop_cnt    = accept ? need : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < ARCH_REGS; r++) rat[r] <= prn_t'(r);
      for (int unsigned e = 0; e < DEPTH; e++)
        fl[e] <= (e < DEPTH - ARCH_REGS) ? prn_t'(e + ARCH_REGS) : '0;
      head       <= '0;
      tail       <= prn_t'(DEPTH - ARCH_REGS);
      free_count <= cnt_t'(DEPTH - ARCH_REGS);
    end else begin
      for (int unsigned i = 0; i < MAX_OPERANDS; i++)
        if (freed_prns_valid[i]) fl[push_idx[i]] <= freed_prns[i];
      // Ascending slot order lets the highest slot win for a repeated ARN.
      if (accept) begin
        for (int unsigned j = 0; j < MAX_OPERANDS; j++)
          if (dst_valid[j])
            for (int unsigned r = 0; r < ARCH_REGS; r++)
              if (dst_arn[j] == 6'(r)) rat[r] <= dst_prn_n[j];
      end
      head       <= head + pop_cnt[PRN_BITS-1:0];
      tail       <= tail + push_cnt[PRN_BITS-1:0];
      free_count <= free_count + push_cnt - pop_cnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_pc    <= '0;
      for (int unsigned j = 0; j < MAX_OPERANDS; j++) begin
        out_src_prn[j]        <= '0;
        out_dst_valid[j]      <= 1'b0;
        out_dst_prn[j]        <= '0;
        mapping_inputs_prn[j] <= '0;
        mapping_inputs_arn[j] <= '0;
      end
    end else if (accept) begin
      out_valid <= 1'b1;
      out_pc    <= pc;
      for (int unsigned j = 0; j < MAX_OPERANDS; j++) begin
        out_src_prn[j]        <= src_prn_n[j];
        out_dst_valid[j]      <= dst_valid[j];
        out_dst_prn[j]        <= dst_prn_n[j];
        mapping_inputs_prn[j] <= map_prn_n[j];
        mapping_inputs_arn[j] <= dst_arn[j];
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign mapping_inputs_valid = out_dst_valid;

endmodule
